led_seq_checker: RTL and testbench
==================================

LED_SEQ_CHECKER -- requirements
Module: led_seq_checker

Interface
REQ-001 Parameter DWELL, default 1: required consecutive sampled cycles per colour (legal range 1..255).
REQ-002 Parameter ERR_W, default 8: width of the error counter.
REQ-003 Port clk, input, 1: single clock; all state updates on posedge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port en, input, 1: sample strobe; led is evaluated only on edges where en=1.
REQ-006 Port led, input, 3: observed one-hot lamp code: 100=RED, 010=GREEN, 001=YELLOW.
REQ-007 Port phase, output, 2: decoded colour of the last sample: 00=RED, 01=GREEN, 10=YELLOW, 11=none/invalid.
REQ-008 Port locked, output, 1: high while the observed sequence is tracked and legal.
REQ-009 Port err, output, 1: one-cycle pulse on a sequence violation while locked.
REQ-010 Port err_cnt, output, ERR_W: saturating violation count.
REQ-011 Port seq_cnt, output, 8: count of completed RED->GREEN->YELLOW->RED rounds while locked; wraps.

Function
REQ-012 Decode: only 100, 010 and 001 are valid; all other codes are invalid (000, 011, 101, 110, 111).
REQ-013 All outputs are registered; each updates on the edge that samples the corresponding led value.
REQ-014 en=0: all state holds; err=0 on that edge.
REQ-015 Internal dwell counter: 8 bits; set to 1 on each new colour; +1 on each repeat of the same colour.
REQ-016 States: SEARCH (locked=0) and LOCKED (locked=1).
REQ-017 SEARCH, valid sample equal to phase: dwell+1, saturating at 255; dwell is not checked against DWELL.
REQ-018 SEARCH, valid sample that is the legal successor of phase (R->G, G->Y, Y->R): load phase, dwell=1, go to LOCKED.
REQ-019 SEARCH, valid sample not equal to phase and not its successor, or phase=11: load phase, dwell=1, stay in SEARCH.
REQ-020 SEARCH, invalid sample: phase=11, stay in SEARCH.
REQ-021 SEARCH never asserts err.
REQ-022 LOCKED, sample equal to phase with dwell<DWELL: dwell+1, no error.
REQ-023 LOCKED, sample is the successor with dwell==DWELL: advance phase, dwell=1.
REQ-024 LOCKED, Y->R advance: seq_cnt+1 modulo 256 on the same edge.
REQ-025 LOCKED, any other sample is a violation:
- over-dwell (same colour with dwell==DWELL)
- early advance (successor with dwell<DWELL)
- skip or reverse
- invalid code
REQ-026 On a violation:
- err=1 for exactly one cycle
- err_cnt+1, saturating at all-ones
- go to SEARCH; locked=0 on the same edge
- valid code: phase loaded, dwell=1
- invalid code: phase=11
REQ-027 err returns to 0 on the next edge regardless of en.
REQ-028 Back-to-back violations cannot occur, because any violation exits LOCKED.

Reset
REQ-029 rst_n=0 immediately and asynchronously forces: state=SEARCH, phase=11, locked=0, err=0, err_cnt=0, seq_cnt=0, dwell=0.
REQ-030 rst_n asserted mid-operation discards all history; the first sample after release behaves as in SEARCH with phase=11.
REQ-031 Reset release is synchronous to clk; no sample is taken on the release edge if rst_n rises within that clock period.

Verification
REQ-032 DWELL=1, en=1, led=100,010,001,100 -> after the 2nd edge: locked=1, phase=01; after the 4th edge: phase=00, seq_cnt=1, err_cnt=0.
REQ-033 DWELL=1, locked on RED, led=001 -> err=1 for one cycle, err_cnt=1, locked=0, phase=10; then 100 relocks with locked=1, err_cnt still 1.
REQ-034 DWELL=1, locked, led=110 -> err pulse, phase=11, locked=0; a following 000 gives no further err.
REQ-035 DWELL=3:
- R,R,R,G,G,G,Y -> no error, locked throughout after the first transition.
- R x3, then G,G,Y -> err on the Y edge.
- R x3 then a 4th R -> err on the 4th R.
REQ-036 en toggling 1/0 every cycle through a legal sequence -> identical results to the contiguous sequence, with no errors.
REQ-037 Counters and reset:
- 256 violations -> err_cnt=255 and holds (ERR_W=8).
- 256 legal rounds -> seq_cnt wraps to 0.
- rst_n pulsed low mid-round -> all outputs at reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/led_seq_checker.sv
// Traffic-lamp sequence checker: decodes a one-hot lamp code, locks onto the
// RED->GREEN->YELLOW cycle with a per-colour dwell, and flags and counts violations.
module led_seq_checker #(
  parameter int unsigned DWELL = 1,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       led,
  output logic [1:0]       phase,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [7:0]       seq_cnt
);

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [1:0] PH_RED    = 2'b00;
  localparam logic [1:0] PH_GREEN  = 2'b01;
  localparam logic [1:0] PH_YELLOW = 2'b10;
  localparam logic [1:0] PH_NONE   = 2'b11;

  localparam logic [7:0] DWELL_C = 8'(DWELL);
  localparam logic [7:0] DWELL_MAX = 8'hFF;

  logic [0:0]       state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [7:0]       dwell_q, dwell_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [7:0]       seq_cnt_q, seq_cnt_d;

  logic [1:0]       samp_phase;
  logic             samp_valid;
  logic             is_same;
  logic             is_succ;

  function automatic logic [1:0] succ_of(input logic [1:0] p);
    case (p)
      PH_RED:    succ_of = PH_GREEN;
      PH_GREEN:  succ_of = PH_YELLOW;
      PH_YELLOW: succ_of = PH_RED;
      default:   succ_of = PH_NONE;
    endcase
  endfunction

  // Only the three pure one-hot codes name a colour.
  always_comb begin
    samp_valid = 1'b1;
    case (led)
      3'b100:  samp_phase = PH_RED;
      3'b010:  samp_phase = PH_GREEN;
      3'b001:  samp_phase = PH_YELLOW;
      default: begin
        samp_phase = PH_NONE;
        samp_valid = 1'b0;
      end
    endcase
  end

  assign is_same = samp_valid && (samp_phase == phase_q);
  assign is_succ = samp_valid && (phase_q != PH_NONE) && (samp_phase == succ_of(phase_q));

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; that is what keeps this block combinational instead of latching.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    dwell_d   = dwell_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    seq_cnt_d = seq_cnt_q;

    if (en) begin
      case (state_q)
        ST_SEARCH: begin
          if (!samp_valid) begin
            phase_d = PH_NONE;
          end else if (is_same) begin
            if (dwell_q != DWELL_MAX) dwell_d = dwell_q + 8'd1;
          end else if (is_succ) begin
            phase_d = samp_phase;
            dwell_d = 8'd1;
            state_d = ST_LOCKED;
          end else begin
            phase_d = samp_phase;
            dwell_d = 8'd1;
          end
        end

        default: begin
          if (is_same && (dwell_q < DWELL_C)) begin
            dwell_d = dwell_q + 8'd1;
          end else if (is_succ && (dwell_q == DWELL_C)) begin
            phase_d = samp_phase;
            dwell_d = 8'd1;
            if (phase_q == PH_YELLOW) seq_cnt_d = seq_cnt_q + 8'd1;
          end else begin
            // Any other sample breaks the sequence; fall back to searching.
            err_d   = 1'b1;
            state_d = ST_SEARCH;
            if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_W'(1);
            if (samp_valid) begin
              phase_d = samp_phase;
              dwell_d = 8'd1;
            end else begin
              phase_d = PH_NONE;
            end
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SEARCH;
      phase_q   <= PH_NONE;
      dwell_q   <= 8'd0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      seq_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      dwell_q   <= dwell_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      seq_cnt_q <= seq_cnt_d;
    end
  end

  assign phase   = phase_q;
  assign locked  = (state_q == ST_LOCKED);
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign seq_cnt = seq_cnt_q;

endmodule

// File: tb/tb_led_seq_checker.sv
// Scoreboard bench for led_seq_checker: the driver queues expected outputs per
// cycle, a negedge monitor pops and compares against one of two DUT instances.
module tb_led_seq_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [2:0] led1 = 3'b000;
  logic [2:0] led3 = 3'b000;

  logic [1:0] phase1, phase3;
  logic       locked1, locked3, err1, err3;
  logic [7:0] err_cnt1, err_cnt3, seq_cnt1, seq_cnt3;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          sel;   // 0: DWELL=1 instance, 1: DWELL=3 instance
    logic [19:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  led_seq_checker #(.DWELL(1), .ERR_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .led(led1),
    .phase(phase1), .locked(locked1), .err(err1),
    .err_cnt(err_cnt1), .seq_cnt(seq_cnt1)
  );

  led_seq_checker #(.DWELL(3), .ERR_W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .led(led3),
    .phase(phase3), .locked(locked3), .err(err3),
    .err_cnt(err_cnt3), .seq_cnt(seq_cnt3)
  );

  function automatic logic [19:0] pk(input int ph, input logic lk, input logic er,
                                     input int ec, input int sc);
    logic [1:0] p2 = ph[1:0];
    logic [7:0] e8 = ec[7:0];
    logic [7:0] s8 = sc[7:0];
    return {p2, lk, er, e8, s8};
  endfunction

  function automatic logic [2:0] led_of(input int c);
    case (c)
      0:       return 3'b100;
      1:       return 3'b010;
      2:       return 3'b001;
      default: return 3'b111;
    endcase
  endfunction

  task automatic check(input string nm, input logic [19:0] act, input logic [19:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got ph=%b lk=%b err=%b ec=%0d sc=%0d, want ph=%b lk=%b err=%b ec=%0d sc=%0d",
               nm, act[19:18], act[17], act[16], act[15:8], act[7:0],
               exp[19:18], exp[17], exp[16], exp[15:8], exp[7:0]);
    end
  endtask

  // One stimulus cycle; the expectation is the DUT output after the next posedge.
  task automatic step(input bit sel, input logic [2:0] l, input logic e,
                      input int ph, input logic lk, input logic er,
                      input int ec, input int sc, input string nm);
    exp_t x;
    @(negedge clk);
    #2;
    en = e;
    if (sel) led3 = l;
    else     led1 = l;
    x.sel  = sel;
    x.exp  = pk(ph, lk, er, ec, sc);
    x.name = nm;
    sb.push_back(x);
  endtask

  task automatic drain();
    @(negedge clk);
    #2;
    if (sb.size() != 0) begin
      bad++;
      total++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset(input string nm);
    drain();
    rst_n = 1'b0;
    en    = 1'b0;
    led1  = 3'b000;
    led3  = 3'b000;
    #1;
    check({nm, "_d1"}, {phase1, locked1, err1, err_cnt1, seq_cnt1}, pk(3, 0, 0, 0, 0));
    check({nm, "_d3"}, {phase3, locked3, err3, err_cnt3, seq_cnt3}, pk(3, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      if (x.sel) check(x.name, {phase3, locked3, err3, err_cnt3, seq_cnt3}, x.exp);
      else       check(x.name, {phase1, locked1, err1, err_cnt1, seq_cnt1}, x.exp);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    do_reset("rst0");

    // DWELL=1 basic round
    step(0, 3'b100, 1, 0, 0, 0, 0, 0, "a_red");
    step(0, 3'b010, 1, 1, 1, 0, 0, 0, "a_green");
    step(0, 3'b001, 1, 2, 1, 0, 0, 0, "a_yellow");
    step(0, 3'b100, 1, 0, 1, 0, 0, 1, "a_round");
    // reverse R->Y, then relock
    step(0, 3'b001, 1, 2, 0, 1, 1, 1, "b_rev_err");
    step(0, 3'b100, 1, 0, 1, 0, 1, 1, "b_relock");
    step(0, 3'b010, 0, 0, 1, 0, 1, 1, "b_en0_hold");
    // invalid code while locked
    step(0, 3'b110, 1, 3, 0, 1, 2, 1, "c_inv_err");
    step(0, 3'b000, 1, 3, 0, 0, 2, 1, "c_inv_noerr");
    // err clears on an en=0 edge
    step(0, 3'b100, 1, 0, 0, 0, 2, 1, "d_load");
    step(0, 3'b010, 1, 1, 1, 0, 2, 1, "d_lock");
    step(0, 3'b100, 1, 0, 0, 1, 3, 1, "d_skip_err");
    step(0, 3'b010, 0, 0, 0, 0, 3, 1, "d_err_clr");

    // en toggling, garbage on idle cycles
    do_reset("rst_mid1");
    step(0, 3'b100, 1, 0, 0, 0, 0, 0, "e_red");
    step(0, 3'b111, 0, 0, 0, 0, 0, 0, "e_idle1");
    step(0, 3'b010, 1, 1, 1, 0, 0, 0, "e_green");
    step(0, 3'b100, 0, 1, 1, 0, 0, 0, "e_idle2");
    step(0, 3'b001, 1, 2, 1, 0, 0, 0, "e_yellow");
    step(0, 3'b000, 0, 2, 1, 0, 0, 0, "e_idle3");
    step(0, 3'b100, 1, 0, 1, 0, 0, 1, "e_round");
    step(0, 3'b001, 0, 0, 1, 0, 0, 1, "e_idle4");

    // DWELL=3 legal round
    do_reset("rst3a");
    step(1, 3'b100, 1, 0, 0, 0, 0, 0, "f_r1");
    step(1, 3'b100, 1, 0, 0, 0, 0, 0, "f_r2");
    step(1, 3'b100, 1, 0, 0, 0, 0, 0, "f_r3");
    step(1, 3'b010, 1, 1, 1, 0, 0, 0, "f_g1");
    step(1, 3'b010, 1, 1, 1, 0, 0, 0, "f_g2");
    step(1, 3'b010, 1, 1, 1, 0, 0, 0, "f_g3");
    step(1, 3'b001, 1, 2, 1, 0, 0, 0, "f_y1");
    step(1, 3'b001, 1, 2, 1, 0, 0, 0, "f_y2");
    step(1, 3'b001, 1, 2, 1, 0, 0, 0, "f_y3");
    step(1, 3'b100, 1, 0, 1, 0, 0, 1, "f_round");
    // locked on R: R x3 then a 4th R is over-dwell
    step(1, 3'b100, 1, 0, 1, 0, 0, 1, "g_r2");
    step(1, 3'b100, 1, 0, 1, 0, 0, 1, "g_r3");
    step(1, 3'b100, 1, 0, 0, 1, 1, 1, "g_overdwell");

    // early advance G,G,Y
    do_reset("rst3b");
    step(1, 3'b100, 1, 0, 0, 0, 0, 0, "h_r1");
    step(1, 3'b100, 1, 0, 0, 0, 0, 0, "h_r2");
    step(1, 3'b100, 1, 0, 0, 0, 0, 0, "h_r3");
    step(1, 3'b010, 1, 1, 1, 0, 0, 0, "h_g1");
    step(1, 3'b010, 1, 1, 1, 0, 0, 0, "h_g2");
    step(1, 3'b001, 1, 2, 0, 1, 1, 0, "h_early");

    // 256 violations saturate err_cnt at 255
    do_reset("rst_sat");
    step(0, led_of(0), 1, 0, 0, 0, 0, 0, "sat_seed");
    c = 0;
    for (int i = 0; i < 256; i++) begin
      c = (c + 1) % 3;
      step(0, led_of(c), 1, c, 1, 0, i, 0, "sat_lock");
      step(0, led_of(c), 1, c, 0, 1, (i + 1 > 255) ? 255 : i + 1, 0, "sat_err");
    end
    step(0, 3'b000, 0, c, 0, 0, 255, 0, "sat_hold");

    // 256 legal rounds wrap seq_cnt
    do_reset("rst_wrap");
    step(0, 3'b100, 1, 0, 0, 0, 0, 0, "w_red");
    step(0, 3'b010, 1, 1, 1, 0, 0, 0, "w_green");
    for (int r = 0; r < 256; r++) begin
      step(0, 3'b001, 1, 2, 1, 0, 0, r % 256, "w_y");
      step(0, 3'b100, 1, 0, 1, 0, 0, (r + 1) % 256, "w_r");
      step(0, 3'b010, 1, 1, 1, 0, 0, (r + 1) % 256, "w_g");
    end
    step(0, 3'b001, 1, 2, 1, 0, 0, 0, "w_mid_y");

    // mid-round reset, then first sample behaves as SEARCH with phase=11
    do_reset("rst_mid2");
    step(0, 3'b010, 1, 1, 0, 0, 0, 0, "z_first_g");
    step(0, 3'b001, 1, 2, 1, 0, 0, 0, "z_lock_y");
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
